// File: rtl/mips_pkg.sv
// Shared MIPS definitions: fetch FSM states, instruction field positions and opcode constants.
package mips_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StDone = 2'b10,
    StErr  = 2'b11
  } fetch_state_e;

  localparam int unsigned OP_HI    = 31;
  localparam int unsigned OP_LO    = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM_HI   = 15;
  localparam int unsigned IMM_LO   = 0;

  localparam logic [31:0] RESET_PC_DEF = 32'h0040_0000;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] FN_ADD   = 6'h20;

endpackage

// File: rtl/instr_fields.sv
// Combinational split of a MIPS instruction word into its decode fields.
module instr_fields
  import mips_pkg::*;
(
  input  logic [31:0] instr,
  output logic [5:0]  op,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [15:0] imm,
  output logic [5:0]  funct
);

  assign op    = instr[OP_HI:OP_LO];
  assign rs    = instr[RS_HI:RS_LO];
  assign rt    = instr[RT_HI:RT_LO];
  assign rd    = instr[RD_HI:RD_LO];
  assign imm   = instr[IMM_HI:IMM_LO];
  assign funct = instr[FUNCT_HI:FUNCT_LO];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, runs the req/ack read with instruction memory, latches IR.
module fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF),
  parameter int unsigned       TIMEOUT  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_start,
  input  logic              pc_write,
  input  logic              pc_src,
  input  logic [ADDR_W-1:0] pc_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              fetch_done,
  output logic              fetch_err,
  output logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic [5:0]        op,
  output logic [5:0]        funct,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [15:0]       imm
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_q, pend_d, pc_inc, pc_sel;
  logic              pend_valid_q, pend_valid_d, start_pend_q, start_pend_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              idle_load, go_fetch, wd_expire;

  assign pc_inc    = pc_q + ADDR_W'(4);
  assign pc_sel    = pc_src ? (pc_target & ~ADDR_W'(3)) : pc_inc;
  assign idle_load = (state_q == StIdle) && (pc_write || pend_valid_q);
  assign go_fetch  = (state_q == StIdle) && (fetch_start || start_pend_q);
  assign wd_expire = (wd_q == WdW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // A PC load in IDLE defers a simultaneous start by one cycle so the fetch sees the new PC.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (go_fetch && !idle_load) state_d = StReq;
      StReq: begin
        if (mem_ack)        state_d = StDone;
        else if (wd_expire) state_d = StErr;
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    mem_req    = (state_q == StReq);
    busy       = (state_q == StReq) || (state_q == StDone);
    fetch_done = (state_q == StDone);
    fetch_err  = (state_q == StErr);
  end

  always_comb begin
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    start_pend_d = start_pend_q;
    instr_d      = instr_q;
    wd_d         = wd_q;
    if (state_q == StIdle) begin
      start_pend_d = go_fetch && idle_load;
      wd_d         = '0;
      pend_valid_d = 1'b0;
      if (pc_write)          pc_d = pc_sel;
      else if (pend_valid_q) pc_d = pend_q;
    end else if (state_q == StReq || state_q == StDone) begin
      if (state_q == StReq) begin
        wd_d = wd_q + WdW'(1);
        if (mem_ack) begin
          instr_d = mem_rdata;
          pc_d    = pc_inc;
        end
      end
      // Mid-fetch PC writes park here until IDLE; last one wins.
      if (pc_write) begin
        pend_d       = pc_sel;
        pend_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      start_pend_q <= 1'b0;
      instr_q      <= '0;
      wd_q         <= '0;
    end else begin
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      start_pend_q <= start_pend_d;
      instr_q      <= instr_d;
      wd_q         <= wd_d;
    end
  end

  assign pc       = pc_q;
  assign mem_addr = pc_q;
  assign instr    = instr_q;

  instr_fields u_fields (
    .instr (instr_q),
    .op    (op),
    .rs    (rs),
    .rt    (rt),
    .rd    (rd),
    .imm   (imm),
    .funct (funct)
  );

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multicycle MIPS datapath, directly upstream of the control FSM. It owns the program counter, runs a req/ack read handshake with instruction memory, and latches the fetched word into the instruction register. It presents the decoded Op/Funct/register/immediate fields that the control FSM and register file consume. A watchdog reports a stalled memory.

## Interface

- ADDR_W, 32, PC and memory address width.
- DATA_W, 32, instruction width; fixed at 32 for MIPS field positions.
- RESET_PC, 32'h0040_0000, PC value after reset; bits [1:0] must be 0.
- TIMEOUT, 16, maximum cycles `mem_req` may wait for `mem_ack` before error.
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_start  in  1  single-cycle pulse from control FSM IF state; start a fetch.
- pc_write  in  1  load new PC from the source selected by `pc_src`.
- pc_src  in  1  0: PC+4 from internal incrementer; 1: `pc_target`.
- pc_target  in  ADDR_W  branch/jump target from the ALU output register.
- mem_req  out  1  instruction read request.
- mem_addr  out  ADDR_W  read address; equals `pc` while `mem_req`=1.
- mem_rdata  in  DATA_W  read data, valid when `mem_ack`=1.
- mem_ack  in  1  read completion.
- busy  out  1  fetch in progress (REQ or DONE).
- fetch_done  out  1  one-cycle pulse: IR updated.
- fetch_err  out  1  sticky: watchdog expired.
- pc  out  ADDR_W  current PC.
- instr  out  DATA_W  instruction register.
- op  out  6  instr[31:26].
- funct  out  6  instr[5:0].
- rs, rt, rd  out  5 each  instr[25:21], [20:16], [15:11].
- imm  out  16  instr[15:0].

## Operation

- States: IDLE, REQ, DONE, ERR. Encoding 2 bits: 00, 01, 10, 11.
- IDLE: `fetch_start`=1 moves to REQ. Otherwise stay in IDLE.
- REQ: `mem_req`=1 and `mem_addr`=`pc`. The watchdog counts the cycles spent in REQ.
  - On `mem_ack`=1: `instr`<=`mem_rdata`, `pc`<=`pc`+4, go to DONE.
  - If the count reaches TIMEOUT with no ack: go to ERR.
- DONE: `fetch_done`=1 for exactly one cycle, then IDLE.
- ERR: `fetch_err`=1 and `mem_req`=0. ERR is left only by `rst`.
- PC arithmetic: the increment is modulo 2^ADDR_W, so 0xFFFF_FFFC+4 wraps to 0. Bits [1:0] of any loaded value are forced to 0.
- `pc_write` in IDLE: the PC loads on the next edge. With `pc_src`=0 it loads `pc`+4; with `pc_src`=1 it loads `pc_target`.
- `pc_write` in REQ/DONE: the PC is not disturbed mid-fetch. The value is captured into a single pending register and applied on the first IDLE cycle. A later `pc_write` overwrites the pending value (last wins).
- `fetch_start` and `pc_write` in the same IDLE cycle: the PC load wins. The fetch then uses the new PC, one cycle later.
- `fetch_start` while busy or in ERR is ignored.
- `mem_ack` outside REQ is ignored.
- Field outputs are combinational slices of `instr` and are stable between fetches.

## Timing

- Reset values:
  - state=IDLE, `pc`=RESET_PC, `instr`=0 (so `op`, `funct`, `rs`, `rt`, `rd`, `imm`=0).
  - `mem_req`=0, `busy`=0, `fetch_done`=0, `fetch_err`=0.
  - Pending register cleared; watchdog=0.
- Latency from `fetch_start` (cycle N):
  - N+1: REQ.
  - If ack comes in N+1: IR/PC update at the N+2 edge, and `fetch_done`=1 during N+2.
  - Minimum start-to-done is 2 cycles. Each ack wait cycle adds 1.
- `mem_req` stays asserted continuously from REQ entry until the ack cycle inclusive.
- Watchdog: ERR is entered after TIMEOUT consecutive REQ cycles without ack.
- Reset mid-fetch: the outstanding request is dropped and `mem_req`=0 in the cycle after `rst`. A late `mem_ack` is ignored.

## Structure

- Shared package `mips_pkg`:
  - Fetch state enum.
  - Field bit-position constants (OP_HI/LO, RS, RT, RD, FUNCT, IMM).
  - RESET_PC default.
  - Opcode/funct constants OP_RTYPE=6'h00, OP_ADDI=6'h08, FN_ADD=6'h20.
- One sub-module, `instr_fields`: a purely combinational split of `instr` into `op`/`rs`/`rt`/`rd`/`imm`/`funct`. The same split is reused by the register-file address path.

## Test plan

- Reset, then pulse `fetch_start` with ack in the first REQ cycle and `mem_rdata`=32'h2008_0005 -> `fetch_done` at cycle N+2, `pc`=0x0040_0004, `op`=6'h08, `rt`=8, `imm`=5.
- Hold ack low 3 cycles with `mem_rdata`=32'h0109_5020 -> `mem_req` high 4 cycles with `mem_addr` stable, then `op`=0, `funct`=6'h20, `rd`=10.
- Assert `pc_write`, `pc_src`=1, `pc_target`=0x0040_0103 during REQ -> `pc`=0x0040_0004 after the fetch, then `pc`=0x0040_0100 in the cycle after IDLE entry.
- Load `pc`=0xFFFF_FFFC, fetch with ack -> `pc`=0x0000_0000.
- Withhold ack for TIMEOUT=16 cycles -> `fetch_err`=1 and `mem_req`=0; a later `fetch_start` has no effect; `rst` clears to IDLE with `pc`=RESET_PC.
- Assert `rst` in the second REQ cycle, then ack -> `mem_req`=0 and `instr` unchanged at 0.
